// File: rtl/rsc_pkg.sv
// Shared constants and FSM encoding for the return-address stack controller.
package rsc_pkg;
  localparam int DEF_ADDR_W = 12;

  localparam logic [2:0] BS_SEQ  = 3'b000;
  localparam logic [2:0] BS_SKIP = 3'b001;
  localparam logic [2:0] BS_JMP  = 3'b010;
  localparam logic [2:0] BS_RET  = 3'b011;
  localparam logic [2:0] BS_ISR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    INISR = 2'd2
  } rsc_state_e;
endpackage

// File: rtl/return_stack_ctrl_if.sv
// Sequencer-facing bundle of the return stack controller; slave = controller side.
interface return_stack_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic              step;
  logic [2:0]        bs;
  logic              call;
  logic              boundary;
  logic [ADDR_W-1:0] pc;
  logic              irq;
  logic              err_clr;
  logic [ADDR_W:0]   stack_addr;
  logic [ADDR_W:0]   isr_addr;
  logic              irq_take;
  logic              int_en;
  logic [SPW-1:0]    sp;
  logic              ovf;
  logic              unf;

  modport master (
    output step, bs, call, boundary, pc, irq, err_clr,
    input  stack_addr, isr_addr, irq_take, int_en, sp, ovf, unf
  );

  modport slave (
    input  step, bs, call, boundary, pc, irq, err_clr,
    output stack_addr, isr_addr, irq_take, int_en, sp, ovf, unf
  );
endinterface

// File: rtl/rsc_lifo.sv
// Return-address LIFO: uncleared register array plus occupancy pointer.
module rsc_lifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [$clog2(DEPTH):0]     sp_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   sp_m1;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_m1   = sp_q - 1'b1;
  assign top_o   = empty_o ? '0 : mem_q[sp_m1[AW-1:0]];
  assign sp_o    = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)
      sp_d = sp_q + 1'b1;
    else if (pop_i && !empty_o)
      sp_d = sp_m1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      sp_q <= '0;
    else
      sp_q <= sp_d;
  end

  // Storage is never reset: an empty stack hides stale entries behind sp.
  always_ff @(posedge clk) begin
    if (rst_n && push_i && !full_o)
      mem_q[sp_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/return_stack_ctrl.sv
// Return-stack and interrupt-entry controller for the microcode sequencer.
// Build option RSC_ERR_STATUS_EN enables sticky ovf/unf flags cleared by err_clr.
module return_stack_ctrl
  import rsc_pkg::*;
#(
  parameter int                   ADDR_W  = DEF_ADDR_W,
  parameter int                   DEPTH   = 8,
  parameter logic [ADDR_W-1:0]    ISR_VEC = 'hF00
) (
  input logic              clk,
  input logic              rst_n,
  return_stack_ctrl_if.slave bus
);
  localparam int SPW = $clog2(DEPTH) + 1;

  rsc_state_e        state_q, state_d;
  logic              int_en_q, int_en_d;
  logic              full, empty;
  logic [ADDR_W:0]   top;
  logic [SPW-1:0]    sp;
  logic [ADDR_W-1:0] pc_inc;
  logic              take, call_req, ret_req, push, pop, flag_pop;

  assign pc_inc   = bus.pc + 1'b1;
  // An interrupt take steals the cycle's single stack slot from call/return.
  assign take     = (state_q == PEND) && int_en_q && bus.boundary && bus.step && !full;
  assign call_req = bus.step && bus.call && (bus.bs == BS_JMP) && !take;
  assign ret_req  = bus.step && (bus.bs == BS_RET) && !take;
  assign push     = take || (call_req && !full);
  assign pop      = ret_req && !empty;
  assign flag_pop = pop && top[ADDR_W];

  rsc_lifo #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({take, pc_inc}),
    .top_o   (top),
    .sp_o    (sp),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d  = state_q;
    int_en_d = int_en_q;
    unique case (state_q)
      IDLE:    if (bus.irq) state_d = PEND;
      PEND:    if (take) begin
                 state_d  = INISR;
                 int_en_d = 1'b0;
               end
      INISR:   if (flag_pop) begin
                 state_d  = IDLE;
                 int_en_d = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      int_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      int_en_q <= int_en_d;
    end
  end

  assign bus.stack_addr = top;
  assign bus.isr_addr   = {1'b0, ISR_VEC};
  assign bus.irq_take   = take;
  assign bus.int_en     = int_en_q;
  assign bus.sp         = sp;

`ifdef RSC_ERR_STATUS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A same-cycle error event overrides the clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (call_req && full)  ovf_d = 1'b1;
    if (ret_req && empty)  unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.ovf = 1'b0;
  assign bus.unf = 1'b0;
`endif
endmodule

// File: tb/tb_return_stack_ctrl.sv
// Directed scenarios plus random traffic checked against a queue-based model.
module tb_return_stack_ctrl;
  localparam int AW = 12;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  return_stack_ctrl_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();

  return_stack_ctrl #(.ADDR_W(AW), .DEPTH(DP), .ISR_VEC(12'hF00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: stack is a queue, interrupt status is three plain flags.
  logic [AW:0] m_stk[$];
  bit m_pend, m_inisr, m_en, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_take();
    return m_pend && m_en && bus.boundary && bus.step && (m_stk.size() < DP);
  endfunction

  task automatic model_step();
    bit take;
    logic [AW:0] e;
    logic [AW-1:0] nxt;
    bit was_idle;
    if (!rst_n) begin
      m_stk.delete();
      m_pend = 0; m_inisr = 0; m_en = 1; m_ovf = 0; m_unf = 0;
      return;
    end
    take = m_take();
    nxt = bus.pc + 12'd1;
    was_idle = !m_pend && !m_inisr;
    if (bus.err_clr) begin m_ovf = 0; m_unf = 0; end
    if (take) begin
      m_stk.push_back({1'b1, nxt});
      m_en = 0; m_pend = 0; m_inisr = 1;
    end else if (bus.step) begin
      if (bus.bs == 3'b010 && bus.call) begin
        if (m_stk.size() == DP) m_ovf = 1;
        else m_stk.push_back({1'b0, nxt});
      end else if (bus.bs == 3'b011) begin
        if (m_stk.size() == 0) m_unf = 1;
        else begin
          e = m_stk.pop_back();
          if (e[AW]) begin m_en = 1; m_inisr = 0; end
        end
      end
    end
    if (was_idle && bus.irq) m_pend = 1;
  endtask

  task automatic cyc(input bit rn, input bit st, input logic [2:0] b, input bit c,
                     input bit bd, input logic [AW-1:0] p, input bit iq, input bit ec);
    logic [AW:0] exp_top;
    @(negedge clk);
    rst_n = rn; bus.step = st; bus.bs = b; bus.call = c; bus.boundary = bd;
    bus.pc = p; bus.irq = iq; bus.err_clr = ec;
    #1;
    exp_top = (m_stk.size() > 0) ? m_stk[$] : '0;
    chk("irq_take",   bus.irq_take,   m_take());
    chk("stack_addr", bus.stack_addr, exp_top);
    chk("sp",         bus.sp,         m_stk.size());
    chk("int_en",     bus.int_en,     m_en);
    chk("isr_addr",   bus.isr_addr,   13'h0F00);
`ifdef RSC_ERR_STATUS_EN
    chk("ovf", bus.ovf, m_ovf);
    chk("unf", bus.unf, m_unf);
`else
    chk("ovf", bus.ovf, 1'b0);
    chk("unf", bus.unf, 1'b0);
`endif
    @(posedge clk);
    model_step();
  endtask

  // step=1 shorthand
  task automatic op(input logic [2:0] b, input bit c, input bit bd, input logic [AW-1:0] p,
                    input bit iq);
    cyc(1'b1, 1'b1, b, c, bd, p, iq, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; bus.step = 0; bus.bs = 0; bus.call = 0; bus.boundary = 0;
    bus.pc = 0; bus.irq = 0; bus.err_clr = 0;
    m_en = 1;
    cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
    cyc(0, 1, 3'b010, 1, 0, 12'h055, 1, 0);
    // single call / return
    op(3'b010, 1, 0, 12'h010, 0);
    op(3'b011, 0, 0, 12'h011, 0);
    op(3'b000, 0, 0, 12'h012, 0);
    // overflow, underflow, clear
    for (int i = 0; i < 8; i++) op(3'b010, 1, 0, AW'(i), 0);
    op(3'b010, 1, 0, 12'h020, 0);
    for (int i = 0; i < 9; i++) op(3'b011, 0, 0, 12'h030, 0);
    cyc(1, 0, 3'b000, 0, 0, 0, 0, 1);
    // call with wrong bs is ignored
    op(3'b000, 1, 0, 12'h040, 0);
    op(3'b011, 1, 0, 12'h041, 0);
    cyc(1, 0, 3'b000, 0, 0, 0, 0, 1);
    // interrupt pulse, later take, nested call in ISR, flagged return with irq held
    op(3'b000, 0, 0, 12'h0F0, 1);
    op(3'b000, 0, 0, 12'h0F1, 0);
    op(3'b000, 0, 1, 12'h100, 0);
    op(3'b010, 1, 0, 12'hF02, 1);
    op(3'b011, 0, 1, 12'hF10, 1);
    op(3'b011, 0, 0, 12'hF03, 1);
    op(3'b000, 0, 0, 12'h102, 1);
    // take coincides with a call
    op(3'b010, 1, 1, 12'h200, 0);
    op(3'b000, 0, 0, 12'hF00, 0);
    op(3'b011, 0, 0, 12'hF01, 0);
    // deferred take when full
    for (int i = 0; i < 8; i++) op(3'b010, 1, 0, AW'(12'h300 + i), 0);
    op(3'b000, 0, 0, 12'h310, 1);
    op(3'b000, 0, 1, 12'h311, 0);
    cyc(1, 0, 3'b000, 0, 1, 12'h312, 0, 0);
    op(3'b011, 0, 0, 12'h313, 0);
    op(3'b000, 0, 1, 12'h320, 0);
    op(3'b011, 0, 0, 12'hF00, 0);
    // mid-operation reset
    op(3'b000, 0, 0, 12'h400, 1);
    cyc(0, 0, 3'b000, 0, 0, 0, 0, 0);
    op(3'b000, 0, 1, 12'h401, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] b;
      int r;
      r = $urandom_range(0, 9);
      b = (r < 4) ? 3'b010 : (r < 7) ? 3'b011 : 3'($urandom_range(0, 4));
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), b,
          1'($urandom), 1'($urandom), AW'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/return_stack_ctrl.md
Name: return_stack_ctrl

Overview:
- Producer side of the microcode branch sequencer. It owns the return-address stack and the interrupt entry logic.
- Supplies `stack_addr` (the return target, used for BS=011) and `isr_addr` (the ISR target, used for BS=100). It also forces BS=100 when an interrupt is taken.
- Sits beside the control store. It watches each executed microinstruction's BS and call bit, pushes return addresses, and pops them on return.

Parameters:
- ADDR_W, 12: microcode address width.
- DEPTH, 8: number of stack entries (power of 2, minimum 2).
- ISR_VEC, 12'h F00: ISR entry microaddress.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- step  in  1  the current microinstruction commits this cycle.
- bs  in  3  branch select of the current microinstruction.
- call  in  1  call bit; meaningful only with bs=010.
- boundary  in  1  the current microinstruction is the last one of a macro-instruction.
- pc  in  ADDR_W  current microaddress.
- irq  in  1  level interrupt request, synchronous to clk.
- stack_addr  out  ADDR_W+1  top of stack: {irq_flag, addr}.
- isr_addr  out  ADDR_W+1  {1'b0, ISR_VEC}, constant.
- irq_take  out  1  force the branch sequencer to BS=100 this cycle.
- int_en  out  1  interrupts enabled.
- sp  out  $clog2(DEPTH)+1  number of occupied entries.
- ovf  out  1  sticky overflow (optional feature).
- unf  out  1  sticky underflow (optional feature).
- err_clr  in  1  clears ovf/unf (optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sp=0, int_en=1, FSM=IDLE, irq_take=0, ovf=0, unf=0.
  - Stack contents are not cleared; stack_addr reads 0 whenever sp=0.
  - Reset mid-operation discards any pending interrupt and all stack entries.
- BS encodings: 000 seq, 001 skip, 010 jump, 011 return, 100 isr.
- stack_addr is combinational: mem[sp-1] when sp>0, else 0. The new value is visible the cycle after a push or pop.
- Push (call): step & call & bs=010 & !irq_take.
  - Writes {0, pc+1} (mod 2^ADDR_W) at mem[sp]; sp+1.
  - If sp=DEPTH: no write, sp unchanged, ovf<=1.
- Pop (return): step & bs=011 & !irq_take.
  - sp-1.
  - If the popped entry has bit ADDR_W=1: int_en<=1, FSM->IDLE.
  - If sp=0: no change, unf<=1.
- A call with bs other than 010 is ignored.
- Interrupt FSM:
  - IDLE: irq=1 -> PEND (request latched). irq may then drop; the request is held.
  - PEND: irq_take=1 combinationally when int_en & boundary & step & sp<DEPTH.
    - On that cycle: push {1, pc+1}, int_en<=0, FSM->INISR.
    - If sp=DEPTH, the take is deferred and the FSM stays in PEND; no ovf.
  - INISR: further irq is ignored and not latched. Exit only via a flagged pop -> IDLE; an irq still high then re-enters PEND next cycle.
- irq_take has priority over the current microinstruction's call or return. That call/return is suppressed with no push/pop of its own, so only one stack operation happens per cycle.
- step=0: no stack or FSM change. irq can still move IDLE->PEND.
- ovf/unf: sticky. err_clr clears them; a same-cycle set wins over clear.

Optional Feature:
- Macro RSC_ERR_STATUS_EN.
- Defined: ovf, unf and err_clr are live as above.
- Undefined: ovf and unf are tied to 0, err_clr is ignored, and no flag registers are built. Overflow/underflow still drop the operation silently.

Decomposition:
- Package rsc_pkg holds:
  - BS_SEQ, BS_SKIP, BS_JMP, BS_RET, BS_ISR localparams.
  - ADDR_W default.
  - FSM state encoding: IDLE, PEND, INISR.
- Sub-module rsc_lifo holds the storage: DEPTH×(ADDR_W+1) register array, sp, push/pop/full/empty, top-of-stack read. return_stack_ctrl holds the FSM, op decode and flags.

Test Plan:
- Reset, then call at pc=12'h010 with step=1 -> sp=1, stack_addr=13'h0011 next cycle. Return -> sp=0, stack_addr=0.
- 8 calls (pc=0..7), then a 9th call at pc=12'h020 -> sp=8, ovf=1, top stays 13'h0008. 9 returns -> sp=0, unf=1. err_clr -> both flags 0.
- Pulse irq one cycle while bs=000, boundary=0 -> FSM=PEND, no take. At pc=12'h100 with boundary=1, step=1 -> irq_take=1 that cycle, stack_addr=13'h1101, int_en=0.
- In ISR, call at pc=12'hF02 and return -> int_en stays 0. Flagged return -> int_en=1, sp=0. irq held high -> PEND again next cycle.
- Take cycle coincides with bs=010, call=1 at pc=12'h200 -> exactly one push {1, 12'h201}, sp+1.
- sp=8 with PEND and boundary=1 -> irq_take=0, ovf unchanged. After one return, the next boundary with step=1 -> take occurs.
